imm_gen_stage: RTL and testbench

Parametrised, registered immediate generator for the RV32I pipeline's ID→EX boundary. Supports all five immediate formats (I/S/B/U/J), XLEN-wide sign extension, and either external format select or internal opcode decode. Adds a valid/stall/flush pipeline register and an illegal-format flag, so the block drops directly into the ID/EX stage.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/imm_extract.sv | 31 +++
 rtl/imm_gen_stage.sv | 67 ++++++
 tb/tb_imm_gen_stage.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: immediate format codes and the major opcodes
// that carry an immediate.
package rv_pkg;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction for the five RV32I formats, sign-extended
// from instr[31] to XLEN. Codes outside IMM_I..IMM_J produce zero.
module imm_extract
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    // NOTE: default first so every path assigns imm32 and no latch is inferred.
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries instr[31] in bit 31, so widening is a plain sign extension.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// ID/EX immediate stage: selects the format (external or opcode-decoded),
// extracts the immediate and registers it with valid/stall/flush control.
module imm_gen_stage
  import rv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  input  logic            stall,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] imm_ext,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  logic [2:0]      fmt;
  logic            fmt_illegal;
  logic [XLEN-1:0] imm_comb;

  always_comb begin
    fmt         = IMM_NONE;
    fmt_illegal = 1'b0;
    if (AUTO_DECODE) begin
      case (instr[6:0])
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
        OP_STORE:                            fmt = IMM_S;
        OP_BRANCH:                           fmt = IMM_B;
        OP_LUI, OP_AUIPC:                    fmt = IMM_U;
        OP_JAL:                              fmt = IMM_J;
        OP_R:                                fmt = IMM_NONE;
        default:                             fmt_illegal = 1'b1;
      endcase
    end else begin
      // Reserved codes pass through as the reported type; the extractor yields zero for them.
      fmt         = imm_src;
      fmt_illegal = (imm_src > IMM_J);
    end
  end

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr (instr),
    .fmt   (fmt),
    .imm   (imm_comb)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      imm_ext   <= '0;
      imm_type  <= '0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      out_valid <= in_valid;
      imm_ext   <= imm_comb;
      imm_type  <= fmt;
      illegal   <= in_valid & fmt_illegal;
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (external select XLEN=32, opcode
// decode XLEN=32, opcode decode XLEN=64) share stimulus; vectors pick one to check.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        stall;
  logic        flush;

  logic        ov0, ov1, ov2;
  logic [31:0] imm0, imm1;
  logic [63:0] imm2;
  logic [2:0]  ty0, ty1, ty2;
  logic        il0, il1, il2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b0)) dut_man32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .imm_src(imm_src),
    .stall(stall), .flush(flush), .out_valid(ov0), .imm_ext(imm0), .imm_type(ty0), .illegal(il0)
  );
  imm_gen_stage #(.XLEN(32), .AUTO_DECODE(1'b1)) dut_auto32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .imm_src(imm_src),
    .stall(stall), .flush(flush), .out_valid(ov1), .imm_ext(imm1), .imm_type(ty1), .illegal(il1)
  );
  imm_gen_stage #(.XLEN(64), .AUTO_DECODE(1'b1)) dut_auto64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .imm_src(imm_src),
    .stall(stall), .flush(flush), .out_valid(ov2), .imm_ext(imm2), .imm_type(ty2), .illegal(il2)
  );

  typedef struct {
    string       name;
    int          sel;
    logic        valid;
    logic [31:0] instr;
    logic [2:0]  src;
    logic        exp_valid;
    logic [63:0] exp_imm;
    logic [2:0]  exp_type;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, int sel, logic valid, logic [31:0] ins, logic [2:0] src,
                              logic ev, logic [63:0] ei, logic [2:0] et, logic el);
    vec_t v;
    v.name = name; v.sel = sel; v.valid = valid; v.instr = ins; v.src = src;
    v.exp_valid = ev; v.exp_imm = ei; v.exp_type = et; v.exp_ill = el;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string name, int sel, logic ev, logic [63:0] ei, logic [2:0] et, logic el);
    logic        av, ail;
    logic [63:0] ai;
    logic [2:0]  at;
    case (sel)
      0:       begin av = ov0; ai = {32'b0, imm0}; at = ty0; ail = il0; end
      1:       begin av = ov1; ai = {32'b0, imm1}; at = ty1; ail = il1; end
      default: begin av = ov2; ai = imm2;          at = ty2; ail = il2; end
    endcase
    check({name, ".out_valid"}, 64'(av), 64'(ev));
    check({name, ".imm_ext"},   ai, ei);
    check({name, ".imm_type"},  64'(at), 64'(et));
    check({name, ".illegal"},   64'(ail), 64'(el));
  endtask

  // Drive on the falling edge, let one rising edge register it, sample 1 ns later.
  task automatic step(logic r, logic v, logic [31:0] ins, logic [2:0] src, logic st, logic fl);
    @(negedge clk);
    rst = r; in_valid = v; instr = ins; imm_src = src; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; imm_src = '0; stall = 1'b0; flush = 1'b0;

    // Reset state on all instances.
    step(1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    check_all("reset_man32", 0, 1'b0, 64'h0, 3'b000, 1'b0);
    check_all("reset_auto64", 2, 1'b0, 64'h0, 3'b000, 1'b0);

    // Manual format select, XLEN=32.
    vecs.push_back(mk("man_i_neg1",  0, 1, 32'hFFF00093, 3'b000, 1, 64'hFFFFFFFF, 3'b000, 0));
    vecs.push_back(mk("man_s_8",     0, 1, 32'h0020A423, 3'b001, 1, 64'h00000008, 3'b001, 0));
    vecs.push_back(mk("man_b_f7fc",  0, 1, 32'hFE000E63, 3'b010, 1, 64'hFFFFF7FC, 3'b010, 0));
    vecs.push_back(mk("man_b_neg4",  0, 1, 32'hFE000EE3, 3'b010, 1, 64'hFFFFFFFC, 3'b010, 0));
    vecs.push_back(mk("man_u",       0, 1, 32'h123450B7, 3'b011, 1, 64'h12345000, 3'b011, 0));
    vecs.push_back(mk("man_j_800",   0, 1, 32'h001000EF, 3'b100, 1, 64'h00000800, 3'b100, 0));
    vecs.push_back(mk("man_rsv101",  0, 1, 32'hFFF00093, 3'b101, 1, 64'h0,        3'b101, 1));
    vecs.push_back(mk("man_rsv111",  0, 1, 32'hFFF00093, 3'b111, 1, 64'h0,        3'b111, 1));
    vecs.push_back(mk("man_inv_rsv", 0, 0, 32'hFFF00093, 3'b101, 0, 64'h0,        3'b101, 0));
    vecs.push_back(mk("man_inv_ld",  0, 0, 32'h7FF00093, 3'b000, 0, 64'h000007FF, 3'b000, 0));
    // Opcode decode, XLEN=32; imm_src deliberately nonsensical.
    vecs.push_back(mk("auto_lui",    1, 1, 32'h123450B7, 3'b101, 1, 64'h12345000, 3'b011, 0));
    vecs.push_back(mk("auto_jal",    1, 1, 32'h001000EF, 3'b000, 1, 64'h00000800, 3'b100, 0));
    vecs.push_back(mk("auto_unk",    1, 1, 32'h0000007F, 3'b000, 1, 64'h0,        3'b111, 1));
    vecs.push_back(mk("auto_rtype",  1, 1, 32'h002080B3, 3'b000, 1, 64'h0,        3'b111, 0));
    vecs.push_back(mk("auto_opimm",  1, 1, 32'hFFF00093, 3'b101, 1, 64'hFFFFFFFF, 3'b000, 0));
    vecs.push_back(mk("auto_store",  1, 1, 32'h0020A423, 3'b111, 1, 64'h00000008, 3'b001, 0));
    vecs.push_back(mk("auto_branch", 1, 1, 32'hFE000EE3, 3'b000, 1, 64'hFFFFFFFC, 3'b010, 0));
    vecs.push_back(mk("auto_jalr",   1, 1, 32'hFFC08067, 3'b011, 1, 64'hFFFFFFFC, 3'b000, 0));
    // Opcode decode, XLEN=64.
    vecs.push_back(mk("a64_lui_neg", 2, 1, 32'h800000B7, 3'b000, 1, 64'hFFFFFFFF80000000, 3'b011, 0));
    vecs.push_back(mk("a64_i_neg1",  2, 1, 32'hFFF00093, 3'b000, 1, 64'hFFFFFFFFFFFFFFFF, 3'b000, 0));
    vecs.push_back(mk("a64_auipc",   2, 1, 32'h7FFFF017, 3'b000, 1, 64'h000000007FFFF000, 3'b011, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(1'b0, vecs[i].valid, vecs[i].instr, vecs[i].src, 1'b0, 1'b0);
      check_all(vecs[i].name, vecs[i].sel, vecs[i].exp_valid, vecs[i].exp_imm,
                vecs[i].exp_type, vecs[i].exp_ill);
    end

    // Stall holds the registered entry while a new instruction waits.
    step(1'b0, 1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 32'h0020A423, 3'b001, 1'b1, 1'b0);
      check_all($sformatf("stall_hold%0d", c), 0, 1'b1, 64'hFFFFFFFF, 3'b000, 1'b0);
    end
    step(1'b0, 1'b1, 32'h0020A423, 3'b001, 1'b0, 1'b0);
    check_all("stall_release", 0, 1'b1, 64'h00000008, 3'b001, 1'b0);

    // Flush beats stall and discards the held entry.
    step(1'b0, 1'b1, 32'hFFF00093, 3'b000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'hFFF00093, 3'b000, 1'b1, 1'b1);
    check_all("flush_over_stall", 0, 1'b0, 64'h0, 3'b000, 1'b0);

    // Flush clears an illegal entry too.
    step(1'b0, 1'b1, 32'hFFF00093, 3'b110, 1'b0, 1'b0);
    check_all("pre_flush_rsv", 0, 1'b1, 64'h0, 3'b110, 1'b1);
    step(1'b0, 1'b1, 32'hFFF00093, 3'b110, 1'b0, 1'b1);
    check_all("flush_rsv", 0, 1'b0, 64'h0, 3'b000, 1'b0);

    // Reset beats stall and an incoming valid instruction.
    step(1'b0, 1'b1, 32'h800000B7, 3'b011, 1'b0, 1'b0);
    check_all("pre_rst_a64", 2, 1'b1, 64'hFFFFFFFF80000000, 3'b011, 1'b0);
    step(1'b1, 1'b1, 32'h800000B7, 3'b011, 1'b1, 1'b0);
    check_all("rst_over_stall_a64", 2, 1'b0, 64'h0, 3'b000, 1'b0);
    check_all("rst_over_stall_m32", 0, 1'b0, 64'h0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 32'hFFF00093, 3'b000, 1'b0, 1'b0);
    check_all("post_rst_load", 0, 1'b1, 64'hFFFFFFFF, 3'b000, 1'b0);
    step(1'b0, 1'b1, 32'hFFF00093, 3'b101, 1'b0, 1'b0);
    check_all("post_rst_rsv", 0, 1'b1, 64'h0, 3'b101, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
